// File: rtl/char_text_buffer.sv
// char_text_buffer
// Writable ROWS x COLS character-cell buffer for the VGA text overlays.
// Cells are addressed as {row, col}, stored row-major (index = row*COLS + col).
// After reset the whole array is filled with SPACE_CODE by an automatic clear.
// A valid/ready port writes single cells, clear_req refills the array with
// SPACE_CODE and scroll_req moves every row up by one and blanks the last row.
// The read port has one cycle of latency and is serviced at all times.
module char_text_buffer #(
  parameter int                COLS       = 16,
  parameter int                ROWS       = 16,
  parameter int                CODE_W     = 7,
  parameter logic [CODE_W-1:0] SPACE_CODE = '0,
  parameter int                COL_W      = (COLS > 1) ? $clog2(COLS) : 1,
  parameter int                ROW_W      = (ROWS > 1) ? $clog2(ROWS) : 1,
  parameter int                XY_W       = ROW_W + COL_W
) (
  input  logic              clk,
  input  logic              rst,
  // write port
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [XY_W-1:0]   wr_xy,
  input  logic [CODE_W-1:0] wr_code,
  // commands
  input  logic              clear_req,
  input  logic              scroll_req,
  output logic              busy,
  output logic              done,
  // read port
  input  logic [XY_W-1:0]   rd_xy,
  output logic [CODE_W-1:0] char_code
);

  // Array geometry.
  localparam int N     = ROWS * COLS;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  // Constants at the widths they are compared or added at.
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] SCROLL_SPLIT = IDX_W'(N - COLS);
  localparam logic [IDX_W-1:0] COLS_IDX     = IDX_W'(COLS);
  localparam logic [COL_W:0]   COLS_LIM     = (COL_W + 1)'(COLS);
  localparam logic [ROW_W:0]   ROWS_LIM     = (ROW_W + 1)'(ROWS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    SCROLL = 2'd2
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  cnt;
  logic [CODE_W-1:0] mem [0:N-1];

  // True when the {row, col} address names a real cell. The column field
  // may exceed COLS when COLS is not a power of two; the row field likewise.
  function automatic logic addr_ok(input logic [XY_W-1:0] xy);
    return ({1'b0, xy[COL_W-1:0]} < COLS_LIM) &&
           ({1'b0, xy[XY_W-1:COL_W]} < ROWS_LIM);
  endfunction

  // Row-major cell index of an in-range {row, col} address.
  function automatic logic [IDX_W-1:0] cell_idx(input logic [XY_W-1:0] xy);
    return IDX_W'(xy[XY_W-1:COL_W]) * COLS_IDX + IDX_W'(xy[COL_W-1:0]);
  endfunction

  logic             wr_fire;
  logic             wr_in_range;
  logic [IDX_W-1:0] wr_idx;
  logic             rd_in_range;
  logic [IDX_W-1:0] rd_idx;
  logic             scroll_copy;
  logic [IDX_W-1:0] scroll_src;

  assign wr_fire     = wr_valid && wr_ready;
  assign wr_in_range = addr_ok(wr_xy);
  assign wr_idx      = cell_idx(wr_xy);
  assign rd_in_range = addr_ok(rd_xy);
  assign rd_idx      = cell_idx(rd_xy);

  // During a scroll, cells below the last row take the cell one row down;
  // cells of the last row are blanked.
  assign scroll_copy = (cnt < SCROLL_SPLIT);
  assign scroll_src  = cnt + COLS_IDX;

  // Command FSM: walks cnt over every cell for CLEAR and SCROLL and keeps
  // wr_ready, busy and done registered alongside the state.
  // NOTE: every register in this file is assigned with <=, so the read port
  // and the scroll copy both see the array as it was before the current edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= CLEAR;
      cnt      <= '0;
      busy     <= 1'b1;
      wr_ready <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // Clear wins over scroll; both start at cell 0 on the next edge.
          if (clear_req) begin
            state    <= CLEAR;
            cnt      <= '0;
            busy     <= 1'b1;
            wr_ready <= 1'b0;
          end else if (scroll_req) begin
            state    <= SCROLL;
            cnt      <= '0;
            busy     <= 1'b1;
            wr_ready <= 1'b0;
          end
        end
        CLEAR, SCROLL: begin
          // Requests arriving here are dropped, not queued.
          if (cnt == LAST_IDX) begin
            state    <= IDLE;
            cnt      <= '0;
            busy     <= 1'b0;
            wr_ready <= 1'b1;
            done     <= 1'b1;
          end else begin
            cnt <= cnt + IDX_W'(1);
          end
        end
        default: begin
          // Unused encoding: recover through a full clear.
          state    <= CLEAR;
          cnt      <= '0;
          busy     <= 1'b1;
          wr_ready <= 1'b0;
        end
      endcase
    end
  end

  // Cell array update: one cell per cycle during commands, one write per
  // cycle in IDLE. Out-of-range writes complete their handshake but store
  // nothing.
  // NOTE: the cell array has no reset; the automatic clear after reset
  // initialises it, so it stays a plain register file without reset fan-out.
  always_ff @(posedge clk) begin
    case (state)
      CLEAR: begin
        mem[cnt] <= SPACE_CODE;
      end
      SCROLL: begin
        if (scroll_copy) begin
          mem[cnt] <= mem[scroll_src];
        end else begin
          mem[cnt] <= SPACE_CODE;
        end
      end
      IDLE: begin
        if (wr_fire && wr_in_range) begin
          mem[wr_idx] <= wr_code;
        end
      end
      default: begin
      end
    endcase
  end

  // Registered read port: one-cycle latency, SPACE_CODE for addresses
  // outside the array, serviced even while a command is running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      char_code <= '0;
    end else if (rd_in_range) begin
      char_code <= mem[rd_idx];
    end else begin
      char_code <= SPACE_CODE;
    end
  end

endmodule

// File: tb/tb_char_text_buffer.sv
// tb_char_text_buffer
// Drives a 16x16 and a 40x30 char_text_buffer with directed and random
// traffic. Expected read data comes from a row/column array model of the
// screen; a monitor pops expected values from per-instance queues whenever a
// read result is due.
module tb_char_text_buffer;

  localparam int         C0  = 16;
  localparam int         R0  = 16;
  localparam int         N0  = C0 * R0;
  localparam int         C1  = 40;
  localparam int         R1  = 30;
  localparam int         N1  = C1 * R1;
  localparam logic [6:0] SPC = 7'h20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: 16x16
  logic       rst0, wr_valid0, wr_ready0, clear_req0, scroll_req0, busy0, done0;
  logic [7:0] wr_xy0, rd_xy0;
  logic [6:0] wr_code0, char_code0;
  // Instance 1: 40x30
  logic        rst1, wr_valid1, wr_ready1, clear_req1, scroll_req1, busy1, done1;
  logic [10:0] wr_xy1, rd_xy1;
  logic [6:0]  wr_code1, char_code1;

  char_text_buffer #(.COLS(C0), .ROWS(R0), .CODE_W(7), .SPACE_CODE(SPC)) dut0 (
    .clk(clk), .rst(rst0),
    .wr_valid(wr_valid0), .wr_ready(wr_ready0), .wr_xy(wr_xy0), .wr_code(wr_code0),
    .clear_req(clear_req0), .scroll_req(scroll_req0), .busy(busy0), .done(done0),
    .rd_xy(rd_xy0), .char_code(char_code0)
  );

  char_text_buffer #(.COLS(C1), .ROWS(R1), .CODE_W(7), .SPACE_CODE(SPC)) dut1 (
    .clk(clk), .rst(rst1),
    .wr_valid(wr_valid1), .wr_ready(wr_ready1), .wr_xy(wr_xy1), .wr_code(wr_code1),
    .clear_req(clear_req1), .scroll_req(scroll_req1), .busy(busy1), .done(done1),
    .rd_xy(rd_xy1), .char_code(char_code1)
  );

  // Screen models, [row][col]
  logic [6:0] m0 [R0][C0];
  logic [6:0] m1 [R1][C1];

  typedef struct {
    logic [10:0] xy;
    logic [6:0]  exp;
  } rd_t;

  rd_t q0[$];
  rd_t q1[$];

  int tests = 0;
  int fails = 0;
  int done_cnt0 = 0;
  int done_cnt1 = 0;

  logic rd_fire0 = 1'b0, rd_fire1 = 1'b0;
  logic rd_pend0 = 1'b0, rd_pend1 = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // A read issued before edge k has its data on char_code after edge k.
  always @(posedge clk) begin
    rd_pend0 <= rd_fire0;
    rd_pend1 <= rd_fire1;
  end

  // Monitor: counts done pulses and checks read data against the scoreboard.
  always @(negedge clk) begin
    if (done0) done_cnt0++;
    if (done1) done_cnt1++;
    if (rd_pend0) begin
      rd_t e;
      if (q0.size() == 0) begin
        tests++; fails++;
        $display("FAIL read0 scoreboard empty: got 0x%0h, want no read", char_code0);
      end else begin
        e = q0.pop_front();
        check($sformatf("read0 xy=0x%0h", e.xy), 32'(char_code0), 32'(e.exp));
      end
    end
    if (rd_pend1) begin
      rd_t e;
      if (q1.size() == 0) begin
        tests++; fails++;
        $display("FAIL read1 scoreboard empty: got 0x%0h, want no read", char_code1);
      end else begin
        e = q1.pop_front();
        check($sformatf("read1 xy=0x%0h", e.xy), 32'(char_code1), 32'(e.exp));
      end
    end
  end

  // ---------------- model ----------------
  function automatic logic [6:0] look0(input logic [7:0] xy);
    return m0[int'(xy[7:4])][int'(xy[3:0])];
  endfunction

  function automatic logic [6:0] look1(input logic [10:0] xy);
    int r, c;
    r = int'(xy[10:6]);
    c = int'(xy[5:0]);
    if (r >= R1 || c >= C1) return SPC;
    return m1[r][c];
  endfunction

  task automatic model_clear0();
    for (int r = 0; r < R0; r++) for (int c = 0; c < C0; c++) m0[r][c] = SPC;
  endtask

  task automatic model_clear1();
    for (int r = 0; r < R1; r++) for (int c = 0; c < C1; c++) m1[r][c] = SPC;
  endtask

  task automatic model_scroll0();
    for (int r = 0; r < R0 - 1; r++) for (int c = 0; c < C0; c++) m0[r][c] = m0[r+1][c];
    for (int c = 0; c < C0; c++) m0[R0-1][c] = SPC;
  endtask

  task automatic model_scroll1();
    for (int r = 0; r < R1 - 1; r++) for (int c = 0; c < C1; c++) m1[r][c] = m1[r+1][c];
    for (int c = 0; c < C1; c++) m1[R1-1][c] = SPC;
  endtask

  // ---------------- drivers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One cycle on instance 0: optional write and optional read at the same edge.
  // The read expectation is taken before the write lands in the model.
  task automatic step0(input logic do_wr, input logic [7:0] wxy, input logic [6:0] wcode,
                       input logic do_rd, input logic [7:0] rxy);
    if (do_rd) begin
      rd_t e;
      e.xy = {3'b000, rxy};
      e.exp = look0(rxy);
      q0.push_back(e);
      rd_xy0 = rxy;
    end
    rd_fire0  = do_rd;
    wr_valid0 = do_wr;
    wr_xy0    = wxy;
    wr_code0  = wcode;
    if (do_wr) m0[int'(wxy[7:4])][int'(wxy[3:0])] = wcode;
    cyc();
    wr_valid0 = 1'b0;
    rd_fire0  = 1'b0;
  endtask

  task automatic step1(input logic do_wr, input logic [10:0] wxy, input logic [6:0] wcode,
                       input logic do_rd, input logic [10:0] rxy);
    int r, c;
    if (do_rd) begin
      rd_t e;
      e.xy = rxy;
      e.exp = look1(rxy);
      q1.push_back(e);
      rd_xy1 = rxy;
    end
    rd_fire1  = do_rd;
    wr_valid1 = do_wr;
    wr_xy1    = wxy;
    wr_code1  = wcode;
    r = int'(wxy[10:6]);
    c = int'(wxy[5:0]);
    if (do_wr && r < R1 && c < C1) m1[r][c] = wcode;
    cyc();
    wr_valid1 = 1'b0;
    rd_fire1  = 1'b0;
  endtask

  // Counts edges until done; edges=0 means the budget ran out.
  task automatic wait_done(input int which, input int budget, output int edges, output int busy_lo);
    edges = 0;
    busy_lo = 0;
    for (int i = 1; i <= budget; i++) begin
      cyc();
      if ((which == 0) ? done0 : done1) begin
        edges = i;
        break;
      end
      if (!((which == 0) ? busy0 : busy1)) busy_lo++;
    end
  endtask

  task automatic read_all0();
    for (int i = 0; i < N0; i++) step0(1'b0, 8'h00, 7'h00, 1'b1, 8'(i));
    cyc(); cyc();
  endtask

  task automatic read_all1();
    for (int r = 0; r < R1; r++)
      for (int c = 0; c < C1; c++)
        step1(1'b0, 11'h0, 7'h00, 1'b1, {5'(r), 6'(c)});
    cyc(); cyc();
  endtask

  // Watchdog
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges, blo, bad, d0;
    rst0 = 1'b1; rst1 = 1'b1;
    wr_valid0 = 0; wr_xy0 = '0; wr_code0 = '0; clear_req0 = 0; scroll_req0 = 0; rd_xy0 = '0;
    wr_valid1 = 0; wr_xy1 = '0; wr_code1 = '0; clear_req1 = 0; scroll_req1 = 0; rd_xy1 = '0;
    repeat (3) @(posedge clk);
    #1;

    // ---- reset values ----
    check("rst busy0", 32'(busy0), 1);
    check("rst wr_ready0", 32'(wr_ready0), 0);
    check("rst done0", 32'(done0), 0);
    check("rst char_code0", 32'(char_code0), 0);
    check("rst busy1", 32'(busy1), 1);
    check("rst wr_ready1", 32'(wr_ready1), 0);

    // ---- post-reset clear, 16x16 ----
    rst0 = 1'b0;
    wait_done(0, 2000, edges, blo);
    check("reset clear edges0", 32'(edges), 32'(N0));
    check("reset clear busy low0", 32'(blo), 0);
    check("reset wr_ready0 with done", 32'(wr_ready0), 1);
    check("reset busy0 with done", 32'(busy0), 0);
    model_clear0();
    cyc();
    check("reset done0 pulse width", 32'(done0), 0);
    check("reset done0 pulses", 32'(done_cnt0), 1);
    read_all0();

    // ---- write / read ----
    check("idle wr_ready0", 32'(wr_ready0), 1);
    step0(1'b1, 8'h05, 7'h41, 1'b0, 8'h00);
    step0(1'b1, 8'hff, 7'h5a, 1'b0, 8'h00);
    begin
      logic [7:0] nb [8];
      nb = '{8'h05, 8'hff, 8'h04, 8'h06, 8'hfe, 8'h15, 8'hef, 8'h00};
      for (int i = 0; i < 8; i++) step0(1'b0, 8'h00, 7'h00, 1'b1, nb[i]);
    end
    // Random traffic with frequent same-edge read/write of one cell.
    for (int i = 0; i < 300; i++) begin
      logic [7:0] wxy, rxy;
      wxy = 8'($urandom);
      rxy = ($urandom_range(0, 3) == 0) ? wxy : 8'($urandom);
      step0(1'($urandom), wxy, 7'($urandom), 1'b1, rxy);
    end
    cyc(); cyc();

    // ---- scroll ----
    for (int r = 0; r < R0; r++)
      for (int c = 0; c < C0; c++)
        step0(1'b1, {4'(r), 4'(c)}, 7'(r + 1), 1'b0, 8'h00);
    scroll_req0 = 1'b1;
    cyc();
    scroll_req0 = 1'b0;
    model_scroll0();
    check("scroll busy0", 32'(busy0), 1);
    check("scroll done0 early", 32'(done0), 0);
    // Writes while busy must not be accepted (cell 0 is already scrolled).
    wr_valid0 = 1'b1; wr_xy0 = 8'h00; wr_code0 = 7'h7f;
    for (int i = 0; i < 3; i++) begin
      check("scroll wr_ready0 low", 32'(wr_ready0), 0);
      cyc();
    end
    wr_valid0 = 1'b0;
    wait_done(0, 2000, edges, blo);
    check("scroll edges0", 32'(edges + 3), 32'(N0));
    check("scroll busy low0", 32'(blo), 0);
    cyc();
    check("scroll done0 pulses", 32'(done_cnt0), 2);
    read_all0();

    // ---- write collides with scroll_req: scroll sees the write ----
    check("collide scroll wr_ready0", 32'(wr_ready0), 1);
    scroll_req0 = 1'b1;
    step0(1'b1, 8'h13, 7'h33, 1'b0, 8'h00);
    scroll_req0 = 1'b0;
    model_scroll0();
    wait_done(0, 2000, edges, blo);
    check("collide scroll edges0", 32'(edges), 32'(N0));
    read_all0();

    // ---- write collides with clear_req; scroll_req mid-clear ignored ----
    check("collide clear wr_ready0", 32'(wr_ready0), 1);
    d0 = done_cnt0;
    clear_req0 = 1'b1;
    step0(1'b1, 8'h10, 7'h0e, 1'b0, 8'h00);
    clear_req0 = 1'b0;
    model_clear0();
    for (int i = 0; i < 50; i++) cyc();
    scroll_req0 = 1'b1;
    cyc();
    scroll_req0 = 1'b0;
    wait_done(0, 2000, edges, blo);
    check("clear edges0", 32'(edges + 51), 32'(N0));
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      cyc();
      if (busy0) bad++;
    end
    check("ignored scroll busy cycles", 32'(bad), 0);
    check("ignored scroll done pulses", 32'(done_cnt0 - d0), 1);
    read_all0();

    // ---- reset mid-scroll ----
    for (int i = 0; i < 40; i++) step0(1'b1, 8'($urandom), 7'($urandom), 1'b0, 8'h00);
    rd_xy0 = 8'h21;
    scroll_req0 = 1'b1;
    cyc();
    scroll_req0 = 1'b0;
    d0 = done_cnt0;
    for (int i = 0; i < 100; i++) cyc();
    rst0 = 1'b1;
    #1;
    check("midreset wr_ready0", 32'(wr_ready0), 0);
    check("midreset busy0", 32'(busy0), 1);
    check("midreset done0", 32'(done0), 0);
    check("midreset char_code0", 32'(char_code0), 0);
    @(posedge clk); @(posedge clk); #1;
    rst0 = 1'b0;
    wait_done(0, 2000, edges, blo);
    check("midreset clear edges0", 32'(edges), 32'(N0));
    model_clear0();
    cyc();
    check("midreset done pulses", 32'(done_cnt0 - d0), 1);
    read_all0();

    // ---- 40x30 instance ----
    rst1 = 1'b0;
    wait_done(1, 3000, edges, blo);
    check("reset clear edges1", 32'(edges), 32'(N1));
    check("reset clear busy low1", 32'(blo), 0);
    check("reset wr_ready1 with done", 32'(wr_ready1), 1);
    model_clear1();
    cyc();
    check("reset done1 pulses", 32'(done_cnt1), 1);
    read_all1();
    // Out-of-range writes are dropped; out-of-range reads give SPACE_CODE.
    step1(1'b1, {5'd3, 6'd45}, 7'h55, 1'b0, 11'h0);
    step1(1'b1, {5'd31, 6'd0}, 7'h56, 1'b0, 11'h0);
    begin
      logic [10:0] ob [6];
      ob = '{{5'd3, 6'd45}, {5'd4, 6'd5}, {5'd3, 6'd5}, {5'd31, 6'd0}, {5'd30, 6'd5}, {5'd29, 6'd63}};
      for (int i = 0; i < 6; i++) step1(1'b0, 11'h0, 7'h00, 1'b1, ob[i]);
    end
    for (int i = 0; i < 400; i++) begin
      logic [10:0] wxy, rxy;
      wxy = 11'($urandom);
      rxy = ($urandom_range(0, 3) == 0) ? wxy : 11'($urandom);
      step1(1'($urandom), wxy, 7'($urandom), 1'b1, rxy);
    end
    step1(1'b1, {5'd1, 6'd39}, 7'h39, 1'b0, 11'h0);
    step1(1'b1, {5'd0, 6'd39}, 7'h11, 1'b0, 11'h0);
    step1(1'b1, {5'd29, 6'd0}, 7'h22, 1'b0, 11'h0);
    scroll_req1 = 1'b1;
    cyc();
    scroll_req1 = 1'b0;
    model_scroll1();
    wait_done(1, 3000, edges, blo);
    check("scroll edges1", 32'(edges), 32'(N1));
    cyc();
    check("scroll done1 pulses", 32'(done_cnt1), 2);
    step1(1'b0, 11'h0, 7'h00, 1'b1, {5'd0, 6'd39});
    step1(1'b0, 11'h0, 7'h00, 1'b1, {5'd28, 6'd0});
    step1(1'b0, 11'h0, 7'h00, 1'b1, {5'd29, 6'd0});
    read_all1();

    check("scoreboard0 drained", 32'(q0.size()), 0);
    check("scoreboard1 drained", 32'(q1.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/char_text_buffer.md
# char_text_buffer

Writable character-cell buffer for the VGA text overlays. It replaces the fixed per-screen character ROMs with one parametrised ROWS×COLS array of character codes, addressed as {row, col} exactly like the existing char_xy lookups. The array is filled with spaces after reset, takes writes through a valid/ready port, and supports clear and scroll-up commands. The read port feeds the font ROM stage of the draw_char pipeline with one-cycle latency.

## Interface

- COLS, 16: characters per row, at least 2, not necessarily a power of 2.
- ROWS, 16: rows, at least 2.
- CODE_W, 7: character code width.
- SPACE_CODE, 7'h00: fill code; top level passes vga_pkg::Spc.
- COL_W, derived: $clog2(COLS), minimum 1. ROW_W is the same for ROWS. XY_W = ROW_W+COL_W.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- wr_valid  in  1  write request.
- wr_ready  out  1  block can accept a write.
- wr_xy  in  XY_W  write address, {row, col}.
- wr_code  in  CODE_W  character to write.
- clear_req  in  1  single-cycle pulse: fill the whole array with SPACE_CODE.
- scroll_req  in  1  single-cycle pulse: move every row up by one and blank the last row.
- busy  out  1  a clear or scroll is in progress.
- done  out  1  one-cycle pulse when a clear or scroll completes, including the clear after reset.
- rd_xy  in  XY_W  read address, {row, col}.
- char_code  out  CODE_W  registered read data.

## Operation

- Storage is a register array of N = ROWS*COLS cells, row-major. Cell index i = row*COLS + col.
- The FSM has three states: IDLE, CLEAR, SCROLL. A cell counter cnt runs from 0 to N-1.
- **Reset:** state=CLEAR, cnt=0, busy=1, wr_ready=0, done=0, char_code=0. The array itself is not reset; the automatic clear initialises it.
- **CLEAR:** each cycle mem[cnt] <= SPACE_CODE and cnt increments. After cell N-1 the FSM goes to IDLE.
- **SCROLL:** each cycle, in ascending order:
  - for cnt < N-COLS: mem[cnt] <= mem[cnt+COLS];
  - otherwise: mem[cnt] <= SPACE_CODE.
  - After cell N-1 the FSM goes to IDLE.
- **IDLE:** wr_ready=1. When wr_valid && wr_ready, mem[wr_xy] <= wr_code.
- **Requests in IDLE:**
  - clear_req has priority over scroll_req.
  - The FSM enters CLEAR or SCROLL on the next edge with cnt=0.
  - A write handshaken in the same cycle as a request is still performed; the command then operates on the updated array.
- **Requests while busy:** clear_req and scroll_req are ignored (not queued). wr_valid waits because wr_ready=0.
- **Out-of-range addresses:**
  - A write with col >= COLS or row >= ROWS completes its handshake but stores nothing.
  - A read with an out-of-range address returns SPACE_CODE.
- **Reads:** always serviced, including while busy; during a command they return partially updated contents. Reads are read-before-write: the value returned is what the cell held before any write on the same edge.

## Timing

- Read latency is 1: rd_xy sampled at edge k appears on char_code after edge k.
- wr_ready and busy are registered:
  - wr_ready = (state==IDLE);
  - busy = (state!=IDLE).
- A command requested at edge T (IDLE):
  - busy=1 and wr_ready=0 after edge T;
  - cells are written on edges T+1 through T+N;
  - after edge T+N: busy=0, wr_ready=1, done=1 for exactly one cycle.
- After reset release, cells are written on edges 1..N. busy=0 and done=1 after edge N.
- Reset asserted mid-command: everything returns to the reset values immediately and a fresh full clear runs. Array contents before the clear completes are undefined.
- A write costs one cycle with no stall in IDLE, so back-to-back writes run at 1 per cycle.

## Test plan

- **Reset:** release rst, then read all 256 cells of the default 16×16 array -> every read returns SPACE_CODE; done pulses exactly once, after edge 256; wr_ready rises on the same edge.
- **Write/read:** write 'A' at 8'h05 and 'Z' at 8'hff -> rd_xy=8'h05 gives 'A' one cycle later and rd_xy=8'hff gives 'Z'; neighbouring cells remain SPACE_CODE.
- **Scroll:** fill row r with code r+1 for r=0..15, then pulse scroll_req -> busy for 256 cycles, then a done pulse; row r reads r+2 for r=0..14 and row 15 reads SPACE_CODE.
- **Collision and ignored request:**
  - In IDLE, assert wr_valid (xy=8'h10, code 7'h0e) together with clear_req -> the write handshakes, then the cleared cell reads SPACE_CODE.
  - Pulse scroll_req mid-clear -> ignored: exactly one done pulse and no scroll afterwards.
- **Non-power-of-2 size:** COLS=40, ROWS=30 -> post-reset done arrives after edge 1200; a write to col 45 is dropped and a read at col 45 returns SPACE_CODE; a scroll moves col 39 of row 1 into row 0.
- **Reset mid-scroll:** assert rst at cnt=100 of a scroll -> wr_ready=0 and busy=1 immediately; after release a full clear runs and done arrives after edge N.
